// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, bus state encoding and bank mask helper for gpio_bank.
package gpio_pkg;

    localparam int MAX_PINS  = 256;
    localparam int MAX_BANKS = 8;

    // Register index, taken from data_addr[9:5].
    typedef enum logic [4:0] {
        REG_IN       = 5'd0,
        REG_OE       = 5'd1,
        REG_OUT      = 5'd2,
        REG_OUT_SET  = 5'd3,
        REG_OUT_CLR  = 5'd4,
        REG_OUT_TGL  = 5'd5,
        REG_POS_EN   = 5'd6,
        REG_NEG_EN   = 5'd7,
        REG_STATUS   = 5'd8,
        REG_IRQ_MASK = 5'd9,
        REG_DEBOUNCE = 5'd10
    } gpio_reg_e;

    // Bus response pipeline: accept -> grant -> response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT    = 2'd1,
        ST_RVALID = 2'd2
    } bus_state_e;

    // Bits of a 32-bit bank that map onto an existing pin; zero for banks past the last pin.
    function automatic logic [31:0] bank_mask(input int num_pins, input logic [2:0] bank);
        logic [31:0] m;
        int          lo;
        lo = 32 * int'(bank);
        m  = '0;
        for (int i = 0; i < 32; i++) m[i] = (lo + i) < num_pins;
        return m;
    endfunction

endpackage

// File: rtl/gpio_if.sv
// gpio_if: peripheral-block data bus between a bus master and the GPIO bank.
interface gpio_if;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/gpio_sync_debounce.sv
// gpio_sync_debounce: pin synchroniser chain plus a two-sample debounce filter
// driven by one prescaler shared by all pins.
module gpio_sync_debounce
    import gpio_pkg::*;
#(
    parameter int NUM_PINS       = 64,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_WIDTH = 16
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PINS-1:0]       i_pins,
    input  logic [DEBOUNCE_WIDTH-1:0] i_limit,
    input  logic                      i_clr,
    output logic [NUM_PINS-1:0]       o_filt,
    output logic                      o_tick
);
    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] r_sync;
    logic [NUM_PINS-1:0]                  r_samp;
    logic [NUM_PINS-1:0]                  r_filt;
    logic [DEBOUNCE_WIDTH-1:0]            r_cnt;
    logic [NUM_PINS-1:0]                  w_sync;
    logic [NUM_PINS-1:0]                  w_eq;
    logic                                 w_tick;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_eq   = ~(w_sync ^ r_samp);
    assign w_tick = (i_limit != '0) && (r_cnt == i_limit);
    assign o_filt = r_filt;
    assign o_tick = w_tick;

    // Shift raw pins through the synchroniser flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_pins;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // Prescaler counts 0..limit and wraps; idle at 0 when filtering is off or on reprogramming.
    always_ff @(posedge clk) begin
        if (!rst || i_clr || w_tick || (i_limit == '0)) r_cnt <= '0;
        else                                            r_cnt <= r_cnt + 1'b1;
    end

    // Bypass when limit is 0; otherwise accept a level only after two equal tick samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_samp <= '0;
            r_filt <= '0;
        end else if (i_limit == '0) begin
            r_filt <= w_sync;
        end else if (w_tick) begin
            r_samp <= w_sync;
            r_filt <= (r_filt & ~w_eq) | (w_sync & w_eq);
        end
    end

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: banked GPIO peripheral with atomic output ops, debounced inputs,
// edge status and a masked registered interrupt.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int          NUM_PINS       = 64,
    parameter logic [19:0] BASE_ADDR      = 20'h00020,
    parameter int          SYNC_STAGES    = 2,
    parameter int          DEBOUNCE_WIDTH = 16
)(
    input  logic                clk,
    input  logic                rst,
    gpio_if.slave               bus,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);
    bus_state_e                r_state, w_state_nxt;
    logic [NUM_PINS-1:0]       r_oe, r_out, r_pos_en, r_neg_en, r_status, r_mask, r_prev;
    logic [DEBOUNCE_WIDTH-1:0] r_deb;
    logic [31:0]               r_rdata;
    logic                      r_irq;

    logic                      w_acc, w_wr, w_deb_wr, w_tick;
    logic [4:0]                w_idx;
    logic [2:0]                w_bank;
    logic [31:0]               w_be, w_lane, w_rd;
    logic [NUM_PINS-1:0]       w_wm, w_wd, w_bits, w_sel, w_filt, w_set, w_clr;
    logic                      w_unused;

    assign w_idx    = bus.data_addr[9:5];
    assign w_bank   = bus.data_addr[4:2];
    // One access per grant: a held request is ignored while the grant is showing.
    assign w_acc    = bus.data_req && (bus.data_addr[31:12] == BASE_ADDR) && !bus.data_gnt;
    assign w_wr     = w_acc && bus.data_we;
    assign w_be     = {{8{bus.data_be[3]}}, {8{bus.data_be[2]}}, {8{bus.data_be[1]}}, {8{bus.data_be[0]}}};
    assign w_lane   = w_be & bank_mask(NUM_PINS, w_bank);
    assign w_bits   = w_wd & w_wm;
    assign w_deb_wr = w_wr && (w_idx == REG_DEBOUNCE) && (w_bank == 3'd0);
    assign w_set    = ((~r_prev & w_filt) & r_pos_en) | ((r_prev & ~w_filt) & r_neg_en);
    assign w_clr    = (w_wr && (w_idx == REG_STATUS)) ? w_bits : '0;
    assign w_unused = ^{bus.data_addr[11:10], bus.data_addr[1:0], w_tick};

    assign gpio_out        = r_out;
    assign gpio_oe         = r_oe;
    assign irq             = r_irq;
    assign bus.data_rdata  = r_rdata;

    gpio_sync_debounce #(
        .NUM_PINS       (NUM_PINS),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_pins  (gpio_in),
        .i_limit (r_deb),
        .i_clr   (w_deb_wr),
        .o_filt  (w_filt),
        .o_tick  (w_tick)
    );

    // Bus state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Bus next state: a new access may be accepted in the response cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_acc) w_state_nxt = ST_GNT;
            ST_GNT:    w_state_nxt = ST_RVALID;
            ST_RVALID: w_state_nxt = w_acc ? ST_GNT : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus handshake outputs decoded from state.
    always_comb begin
        bus.data_gnt    = (r_state == ST_GNT);
        bus.data_rvalid = (r_state == ST_RVALID);
    end

    // Spread the addressed 32-bit bank and its enabled lanes across the pin vector.
    always_comb begin
        w_wm = '0;
        w_wd = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            w_wd[p] = bus.data_wdata[p % 32];
            w_wm[p] = w_wr && (int'(w_bank) == p / 32) && w_lane[p % 32];
        end
    end

    // Read mux: pick the register, then the addressed bank of it.
    always_comb begin
        w_sel = '0;
        case (w_idx)
            REG_IN:       w_sel = w_filt;
            REG_OE:       w_sel = r_oe;
            REG_OUT:      w_sel = r_out;
            REG_POS_EN:   w_sel = r_pos_en;
            REG_NEG_EN:   w_sel = r_neg_en;
            REG_STATUS:   w_sel = r_status;
            REG_IRQ_MASK: w_sel = r_mask;
            default:      w_sel = '0;
        endcase
        w_rd = '0;
        for (int p = 0; p < NUM_PINS; p++)
            if (int'(w_bank) == p / 32) w_rd[p % 32] = w_sel[p];
        if ((w_idx == REG_DEBOUNCE) && (w_bank == 3'd0)) w_rd[DEBOUNCE_WIDTH-1:0] = r_deb;
    end

    // Read data captured at accept and held until the next read.
    always_ff @(posedge clk) begin
        if (!rst)                          r_rdata <= '0;
        else if (w_acc && !bus.data_we)    r_rdata <= w_rd;
    end

    // Control register writes, including the atomic set/clear/toggle views of OUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_oe     <= '0;
            r_out    <= '0;
            r_pos_en <= '0;
            r_neg_en <= '0;
            r_mask   <= '0;
            r_deb    <= '0;
        end else if (w_wr) begin
            case (w_idx)
                REG_OE:       r_oe     <= (r_oe & ~w_wm) | w_bits;
                REG_OUT:      r_out    <= (r_out & ~w_wm) | w_bits;
                REG_OUT_SET:  r_out    <= r_out | w_bits;
                REG_OUT_CLR:  r_out    <= r_out & ~w_bits;
                REG_OUT_TGL:  r_out    <= r_out ^ w_bits;
                REG_POS_EN:   r_pos_en <= (r_pos_en & ~w_wm) | w_bits;
                REG_NEG_EN:   r_neg_en <= (r_neg_en & ~w_wm) | w_bits;
                REG_IRQ_MASK: r_mask   <= (r_mask & ~w_wm) | w_bits;
                REG_DEBOUNCE:
                    if (w_bank == 3'd0)
                        r_deb <= (r_deb & ~w_be[DEBOUNCE_WIDTH-1:0])
                               | (bus.data_wdata[DEBOUNCE_WIDTH-1:0] & w_be[DEBOUNCE_WIDTH-1:0]);
                default: ;
            endcase
        end
    end

    // Edge history, sticky status (a new edge beats a same-cycle clear) and registered irq.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_prev   <= w_filt;
            r_status <= (r_status & ~w_clr) | w_set;
            r_irq    <= |(r_status & r_mask);
        end
    end

endmodule
